// File: rtl/vga_sync.sv
`timescale 1ns/1ps
// vga_sync: 640x480@60 timing generator with a fetch-ahead pixel pipeline.
// All display outputs lag the counter position by FETCH_LAT+2 cycles.
module vga_sync #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int FETCH_LAT = 2,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          clr_n,
  output logic          fetch_req,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  input  logic [11:0]   pix_in,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [11:0]   rgb,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = 4 * (FETCH_LAT + 1);

  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic first;
  } tag_t;

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  tag_t          cur;
  tag_t          tap;
  logic [DW-1:0] dl_q, dl_d;

  logic          fetch_req_q, fetch_req_d;
  logic [CW-1:0] fetch_x_q, fetch_x_d;
  logic [CW-1:0] fetch_y_q, fetch_y_d;
  logic          de_q, de_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          fs_q, fs_d;

  always_comb begin
    hc_d = hc_q + CW'(1);
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
    end
  end

  always_comb begin
    cur.vis   = (hc_q < H_VIS) && (vc_q < V_VIS);
    cur.hs    = (hc_q >= HS_BEG) && (hc_q <= HS_END);
    cur.vs    = (vc_q >= VS_BEG) && (vc_q <= VS_END);
    cur.first = (hc_q == '0) && (vc_q == '0);
  end

  always_comb begin
    fetch_req_d = cur.vis;
    fetch_x_d   = cur.vis ? hc_q : '0;
    fetch_y_d   = cur.vis ? vc_q : '0;
  end

  // Slot 0 is aligned with stage F; the oldest slot meets pix_in.
  always_comb dl_d = {dl_q[DW-5:0], cur};
  assign tap = tag_t'(dl_q[DW-1 -: 4]);

  always_comb begin
    de_d    = tap.vis;
    rgb_d   = tap.vis ? pix_in : 12'h000;
    hsync_d = tap.hs ? SYNC_POL : ~SYNC_POL;
    vsync_d = tap.vs ? SYNC_POL : ~SYNC_POL;
    fs_d    = tap.first;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      hc_q        <= '0;
      vc_q        <= '0;
      dl_q        <= '0;
      fetch_req_q <= 1'b0;
      fetch_x_q   <= '0;
      fetch_y_q   <= '0;
      de_q        <= 1'b0;
      rgb_q       <= 12'h000;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      fs_q        <= 1'b0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      dl_q        <= dl_d;
      fetch_req_q <= fetch_req_d;
      fetch_x_q   <= fetch_x_d;
      fetch_y_q   <= fetch_y_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      fs_q        <= fs_d;
    end
  end

  assign fetch_req   = fetch_req_q;
  assign fetch_x     = fetch_x_q;
  assign fetch_y     = fetch_y_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule
